// File: rtl/dp_executor.sv
// Datapath executor: runs one NOP/DRAW/LOAD/STORE command per start edge,
// driving a VGA plot port and a data RAM with 1-cycle read latency.
module dp_executor #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int RESULT_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH    = 16,
    parameter int X_COORD_WIDTH     = 8,
    parameter int Y_COORD_WIDTH     = 7,
    parameter int COLOUR_WIDTH      = 3
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         finished,
    output logic [RESULT_WIDTH-1:0]      result,
    output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
    output logic                         mem_wren,
    output logic [RESULT_WIDTH-1:0]      mem_data_out,
    input  logic [RESULT_WIDTH-1:0]      mem_data_in,
    output logic [X_COORD_WIDTH-1:0]     vga_x,
    output logic [Y_COORD_WIDTH-1:0]     vga_y,
    output logic [COLOUR_WIDTH-1:0]      vga_colour,
    output logic                         vga_plot,
    output logic                         illegal_op
);

    typedef enum logic [2:0] {
        IDLE, DECODE, PLOT, RD, RD_WAIT, WR
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_DRAW  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;

    state_t                         state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic                           start_q;
    logic                           armed_q;
    logic                           finished_q, finished_d;
    logic [RESULT_WIDTH-1:0]        result_q, result_d;
    logic [MEM_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic                           wren_q, wren_d;
    logic [RESULT_WIDTH-1:0]        wdata_q, wdata_d;
    logic [X_COORD_WIDTH-1:0]       x_q, x_d;
    logic [Y_COORD_WIDTH-1:0]       y_q, y_d;
    logic [COLOUR_WIDTH-1:0]        colour_q, colour_d;
    logic                           plot_q, plot_d;
    logic                           illegal_q, illegal_d;

    logic [3:0]  opcode;
    logic        f_plot;
    logic [2:0]  f_colour;
    logic [6:0]  f_y;
    logic [7:0]  f_x;
    logic [15:0] f_addr;
    logic [11:0] f_data;
    logic        draw_ok;
    logic        accept;

    assign opcode   = instr_q[31:28];
    assign f_plot   = instr_q[18];
    assign f_colour = instr_q[17:15];
    assign f_y      = instr_q[14:8];
    assign f_x      = instr_q[7:0];
    assign f_addr   = instr_q[15:0];
    assign f_data   = instr_q[27:16];
    assign draw_ok  = f_plot && (f_x < 8'd160) && (f_y < 7'd120);

    // armed_q blocks a start that was already high when reset released
    assign accept = (state_q == IDLE) && start && !start_q && armed_q;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        finished_d = finished_q;
        result_d   = result_q;
        addr_d     = addr_q;
        wren_d     = 1'b0;
        wdata_d    = wdata_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        illegal_d  = illegal_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d    = instruction;
                    finished_d = 1'b0;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                unique case (opcode)
                    OP_NOP: begin
                        result_d   = '0;
                        finished_d = 1'b1;
                        state_d    = IDLE;
                    end
                    OP_DRAW: begin
                        x_d      = X_COORD_WIDTH'(f_x);
                        y_d      = Y_COORD_WIDTH'(f_y);
                        colour_d = COLOUR_WIDTH'(f_colour);
                        plot_d   = draw_ok;
                        result_d = '0;
                        state_d  = PLOT;
                    end
                    OP_LOAD: begin
                        addr_d  = MEM_ADDR_WIDTH'(f_addr);
                        state_d = RD;
                    end
                    OP_STORE: begin
                        addr_d   = MEM_ADDR_WIDTH'(f_addr);
                        wdata_d  = RESULT_WIDTH'(f_data);
                        wren_d   = 1'b1;
                        result_d = RESULT_WIDTH'(f_data);
                        state_d  = WR;
                    end
                    default: begin
                        illegal_d  = 1'b1;
                        result_d   = '0;
                        finished_d = 1'b1;
                        state_d    = IDLE;
                    end
                endcase
            end
            PLOT: begin
                finished_d = 1'b1;
                state_d    = IDLE;
            end
            RD: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                result_d   = mem_data_in;
                finished_d = 1'b1;
                state_d    = IDLE;
            end
            WR: begin
                finished_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                finished_d = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            start_q    <= 1'b0;
            armed_q    <= ~start;
            finished_q <= 1'b1;
            result_q   <= '0;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            start_q    <= start;
            armed_q    <= armed_q | ~start;
            finished_q <= finished_d;
            result_q   <= result_d;
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            wdata_q    <= wdata_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            illegal_q  <= illegal_d;
        end
    end

    assign finished     = finished_q;
    assign result       = result_q;
    assign mem_address  = addr_q;
    assign mem_wren     = wren_q;
    assign mem_data_out = wdata_q;
    assign vga_x        = x_q;
    assign vga_y        = y_q;
    assign vga_colour   = colour_q;
    assign vga_plot     = plot_q;
    assign illegal_op   = illegal_q;

endmodule
